corelet_ctrl: RTL

Sequencer for one corelet (L0 FIFO → MAC array → OFIFO → SFP). It runs a full convolution pass with no other controller involved. For each kernel position it loads weights from activation/weight SRAM into the array. It then streams activations, executes, and drains partial sums to psum SRAM. After the last kernel position it accumulates the stored psums through the SFP and writes the results to output SRAM. It sits beside the corelet at core level and drives every corelet control input.

---
 rtl/corelet_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequences weight load, execute, psum drain and SFP accumulation for one corelet.
// Define CORELET_CTRL_RELU_EN to assert relu on every output write.
module corelet_ctrl #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int NIJ     = 36,
    parameter int KIJ_NUM = 9,
    parameter int ADDR_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              l0_full,
    input  logic              l0_ready,
    input  logic              ofifo_valid,
    output logic              xmem_rd,
    output logic [ADDR_W-1:0] xmem_addr,
    output logic              load,
    output logic              execute,
    output logic              l0_wr,
    output logic              l0_rd,
    output logic              ofifo_rd,
    output logic              accumulate,
    output logic              relu,
    output logic              pmem_wr,
    output logic              pmem_rd,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic              omem_wr,
    output logic [ADDR_W-1:0] omem_addr,
    output logic              busy,
    output logic              done
);
    localparam int IW = $clog2(COL + 1);
    localparam int SW = $clog2(ROW + COL + 1);
    localparam int NW = $clog2(NIJ + 1);
    localparam int KW = $clog2(KIJ_NUM + 1);
    localparam logic [IW-1:0] I_LAST = IW'(COL - 1);
    localparam logic [IW-1:0] I_END = IW'(COL);
    localparam logic [SW-1:0] S_LAST = SW'(ROW + COL - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NIJ - 1);
    localparam logic [NW-1:0] N_END = NW'(NIJ);
    localparam logic [KW-1:0] K_LAST = KW'(KIJ_NUM - 1);
    localparam logic [KW-1:0] K_END = KW'(KIJ_NUM);
    localparam logic [ADDR_W-1:0] A_NIJ = ADDR_W'(NIJ);
    localparam logic [ADDR_W-1:0] A_COL = ADDR_W'(COL);
`ifdef CORELET_CTRL_RELU_EN
    localparam logic RELU_ON = 1'b1;
`else
    localparam logic RELU_ON = 1'b0;
`endif

    typedef enum logic [3:0] {IDLE, W_WR, W_LD, W_SETTLE, X_WR, X_EX, O_DR, ACC, DONE} state_t;

    state_t state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [SW-1:0] s_q, s_d;
    logic [NW-1:0] k_q, k_d, m_q, m_d, o_q, o_d;
    logic [KW-1:0] j_q, j_d, kij_q, kij_d;
    logic l0_wr_q, l0_wr_d, pmem_wr_q, pmem_wr_d, acc_q, acc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            s_q       <= '0;
            k_q       <= '0;
            m_q       <= '0;
            o_q       <= '0;
            j_q       <= '0;
            kij_q     <= '0;
            l0_wr_q   <= 1'b0;
            pmem_wr_q <= 1'b0;
            acc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            s_q       <= s_d;
            k_q       <= k_d;
            m_q       <= m_d;
            o_q       <= o_d;
            j_q       <= j_d;
            kij_q     <= kij_d;
            l0_wr_q   <= l0_wr_d;
            pmem_wr_q <= pmem_wr_d;
            acc_q     <= acc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        s_d       = s_q;
        k_d       = k_q;
        m_d       = m_q;
        o_d       = o_q;
        j_d       = j_q;
        kij_d     = kij_q;
        xmem_rd   = 1'b0;
        xmem_addr = '0;
        load      = 1'b0;
        execute   = 1'b0;
        l0_rd     = 1'b0;
        ofifo_rd  = 1'b0;
        pmem_rd   = 1'b0;
        pmem_addr = '0;
        omem_wr   = 1'b0;
        omem_addr = '0;
        done      = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = W_WR;
                kij_d   = '0;
                i_d     = '0;
            end
            W_WR: begin
                xmem_rd   = (i_q != I_END);
                xmem_addr = A_NIJ + ADDR_W'(kij_q) * A_COL + ADDR_W'(i_q);
                i_d       = xmem_rd ? i_q + 1'b1 : '0;
                if (!xmem_rd) state_d = W_LD;
            end
            W_LD: begin
                load  = 1'b1;
                l0_rd = 1'b1;
                i_d   = (i_q == I_LAST) ? '0 : i_q + 1'b1;
                if (i_q == I_LAST) begin
                    state_d = W_SETTLE;
                    s_d     = '0;
                end
            end
            W_SETTLE: begin
                s_d = s_q + 1'b1;
                if (s_q == S_LAST) begin
                    state_d = X_WR;
                    k_d     = '0;
                end
            end
            X_WR: begin
                xmem_addr = ADDR_W'(k_q);
                xmem_rd   = (k_q != N_END) && !l0_full;
                k_d       = (k_q == N_END) ? '0 : k_q + NW'(xmem_rd);
                if (k_q == N_END) state_d = X_EX;
            end
            X_EX: begin
                execute = l0_ready;
                l0_rd   = l0_ready;
                if (l0_ready) k_d = (k_q == N_LAST) ? '0 : k_q + 1'b1;
                if (l0_ready && k_q == N_LAST) begin
                    state_d = O_DR;
                    m_d     = '0;
                end
            end
            O_DR: begin
                // k counts accepted reads, m counts the psum writes trailing them
                ofifo_rd = (k_q != N_END) && ofifo_valid;
                k_d      = k_q + NW'(ofifo_rd);
                if (pmem_wr_q) begin
                    pmem_addr = ADDR_W'(kij_q) * A_NIJ + ADDR_W'(m_q);
                    m_d       = m_q + 1'b1;
                end
                if (pmem_wr_q && m_q == N_LAST) begin
                    state_d = (kij_q == K_LAST) ? ACC : W_WR;
                    kij_d   = (kij_q == K_LAST) ? kij_q : kij_q + 1'b1;
                    m_d     = '0;
                    k_d     = '0;
                    o_d     = '0;
                    j_d     = '0;
                    i_d     = '0;
                end
            end
            ACC: begin
                // j parks at KIJ_NUM for the trailing accumulate, then finalizes once acc_q drops
                pmem_rd   = (j_q != K_END);
                pmem_addr = pmem_rd ? ADDR_W'(j_q) * A_NIJ + ADDR_W'(o_q) : '0;
                omem_wr   = !pmem_rd && !acc_q;
                omem_addr = omem_wr ? ADDR_W'(o_q) : '0;
                j_d       = omem_wr ? '0 : j_q + KW'(pmem_rd);
                if (omem_wr) begin
                    o_d = (o_q == N_LAST) ? '0 : o_q + 1'b1;
                    if (o_q == N_LAST) state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                kij_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        relu       = omem_wr & RELU_ON;
        l0_wr      = l0_wr_q;
        pmem_wr    = pmem_wr_q;
        accumulate = acc_q;
        busy       = (state_q != IDLE) && (state_q != DONE);
        l0_wr_d    = xmem_rd;
        pmem_wr_d  = ofifo_rd;
        acc_d      = pmem_rd;
    end
endmodule
